// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a power-of-two byte FIFO feeding a four-state serializer.
// RsTx and sent are registered, so they trail the FSM state by exactly one cycle.
module uart_tx_buffered #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       wr_en,
    output logic       full,
    output logic       empty,
    output logic       overflow,
    output logic       RsTx,
    output logic       sending,
    output logic       sent
);

    localparam int BIT_TICKS = CLOCK_FREQ / BAUD_RATE;
    localparam int CW        = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam int AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CW-1:0] TICK_LAST = CW'(BIT_TICKS - 1);
    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic [CW-1:0] baud_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          stop_done_q;
    logic          sent_q;
    logic          overflow_q;
    logic          push;
    logic          pop;
    logic          drop;
    logic          bit_done;

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign push     = wr_en && !full;
    assign drop     = wr_en && full;
    assign pop      = (state_q == IDLE) && !empty;
    assign bit_done = (baud_q == TICK_LAST);

    assign overflow = overflow_q;
    assign RsTx     = tx_q;
    assign sending  = (state_q != IDLE);
    assign sent     = sent_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage is not reset: only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
            tx_q        <= 1'b1;
            stop_done_q <= 1'b0;
            sent_q      <= 1'b0;
        end else begin
            sent_q      <= stop_done_q;
            stop_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    baud_q <= '0;
                    if (pop) begin
                        shift_q <= mem_q[rd_ptr_q];
                        state_q <= START;
                    end
                end
                START: begin
                    tx_q <= 1'b0;
                    if (bit_done) begin
                        baud_q  <= '0;
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                DATA: begin
                    tx_q <= shift_q[0];
                    if (bit_done) begin
                        baud_q    <= '0;
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                STOP: begin
                    tx_q <= 1'b1;
                    if (bit_done) begin
                        baud_q      <= '0;
                        state_q     <= IDLE;
                        stop_done_q <= 1'b1;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: a frame-level queue model predicts every output each cycle,
// and a mid-bit serial decoder checks received bytes against the expected queue.
module tb_uart_tx_buffered;

  localparam int CLOCK_FREQ = 40;
  localparam int BAUD_RATE  = 10;
  localparam int FIFO_DEPTH = 4;
  localparam int BT         = CLOCK_FREQ / BAUD_RATE;
  localparam int FRAME      = 10 * BT;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic       full, empty, overflow, RsTx, sending, sent;

  int checks = 0;
  int failures = 0;

  uart_tx_buffered #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .wr_en   (wr_en),
    .full    (full),
    .empty   (empty),
    .overflow(overflow),
    .RsTx    (RsTx),
    .sending (sending),
    .sent    (sent)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // reference model: a byte queue plus a countdown of the frame in flight
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  int         busy = 0;
  logic [7:0] cur = 8'd0;
  logic       m_ovf = 1'b0;
  logic       m_fin = 1'b0;
  logic       m_sent = 1'b0;
  logic       m_line = 1'b1;

  function automatic logic line_of(input logic [7:0] b, input int elapsed);
    int idx;
    idx = elapsed / BT;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int size;
    bit do_pop;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      busy   = 0;
      m_ovf  = 1'b0;
      m_fin  = 1'b0;
      m_sent = 1'b0;
      m_line = 1'b1;
    end else begin
      size   = mq.size();
      do_pop = (busy == 0) && (size > 0);
      m_line = (busy == 0) ? 1'b1 : line_of(cur, FRAME - busy);
      m_sent = m_fin;
      m_fin  = (busy == 1);
      if (do_pop) begin
        cur  = mq.pop_front();
        busy = FRAME;
        exp_q.push_back(cur);
      end else if (busy > 0) begin
        busy--;
      end
      if (wr_en) begin
        if (size < FIFO_DEPTH) mq.push_back(data_in);
        else m_ovf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("cycle_outputs", {26'd0, RsTx, sending, sent, full, empty, overflow},
          {26'd0, m_line, (busy > 0), m_sent, (mq.size() == FIFO_DEPTH), (mq.size() == 0), m_ovf});
  end

  // scoreboard: serial decoder sampling mid-bit
  int         rx_t = -1;
  int         rx_count = 0;
  logic [7:0] rx_b = 8'd0;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      rx_t = -1;
    end else if (rx_t < 0) begin
      if (RsTx == 1'b0) rx_t = 0;
    end else begin
      rx_t++;
      if ((rx_t % BT) == BT / 2 && rx_t / BT >= 1 && rx_t / BT <= 8) rx_b[rx_t/BT-1] = RsTx;
      if (rx_t == 9 * BT + BT / 2) begin
        check("rx_stop_bit", RsTx, 1);
        check("rx_expected_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("rx_byte", rx_b, exp_q.pop_front());
        rx_count++;
        rx_t = -1;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("reset_values", {RsTx, sending, sent, full, empty, overflow}, 6'b100010);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((busy != 0 || mq.size() != 0 || rx_t >= 0) && n < (FIFO_DEPTH + 2) * (FRAME + 1)) begin
      tick();
      n++;
    end
    tick();
    tick();
    check({name, "_drained"}, n < (FIFO_DEPTH + 2) * (FRAME + 1), 1);
    check({name, "_all_received"}, exp_q.size(), 0);
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       sending;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base;
    int fall_i, sent_i, sent_n, n_act, next, n;
    logic [9:0] bits;
    int pct[3];

    // overflow table: consecutive writes from idle, transmitter pops the first byte
    vecs[0] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};

    do_reset();
    base = rx_count;
    for (int i = 0; i < 7; i++) begin
      wr_en   = vecs[i].wr;
      data_in = vecs[i].d;
      tick();
      check($sformatf("vec%0d_flags", i), {full, empty, overflow, sending},
            {vecs[i].full, vecs[i].empty, vecs[i].ovf, vecs[i].sending});
    end
    wr_en = 1'b0;
    drain("overflow");
    check("overflow_rx_count", rx_count - base, FIFO_DEPTH + 1);
    check("overflow_sticky", overflow, 1);

    // single byte 0xA5: latency, mid-bit samples, sent pulse
    do_reset();
    data_in = 8'hA5;
    wr_en   = 1'b1;
    tick();
    wr_en  = 1'b0;
    fall_i = -1;
    sent_i = -1;
    sent_n = 0;
    bits   = 10'd0;
    for (int i = 1; i <= 12 * BT; i++) begin
      tick();
      if (RsTx == 1'b0 && fall_i < 0) fall_i = i;
      if (sent) begin
        sent_n++;
        if (sent_i < 0) sent_i = i;
      end
      for (int j = 0; j < 10; j++) if (i == 2 + j * BT + BT / 2) bits[j] = RsTx;
    end
    check("a5_fall_latency", fall_i, 2);
    check("a5_line_bits", bits, 10'b1101001010);
    check("a5_sent_after_start", sent_i - fall_i, FRAME);
    check("a5_sent_pulses", sent_n, 1);

    // burst of three bytes on consecutive cycles
    do_reset();
    base = rx_count;
    wr_en = 1'b1;
    data_in = 8'h55; tick();
    data_in = 8'hAA; tick();
    data_in = 8'h33; tick();
    wr_en = 1'b0;
    n = 0;
    while (!empty && n < 4 * (FRAME + 1)) begin
      tick();
      n++;
    end
    check("burst_empty_in_third_frame", {sending, 8'(rx_count - base)}, {1'b1, 8'd2});
    drain("burst");
    check("burst_rx_count", rx_count - base, 3);

    // wrap: 40 sequential bytes written whenever there is room
    do_reset();
    base = rx_count;
    next = 0;
    n = 0;
    while (next < 40 && n < 5000) begin
      if (!full) begin
        data_in = 8'(next);
        wr_en   = 1'b1;
        next++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      n++;
    end
    wr_en = 1'b0;
    drain("wrap");
    check("wrap_rx_count", rx_count - base, 40);
    check("wrap_no_overflow", overflow, 0);

    // reset during data bit 3 of 0xF0 with two bytes queued
    do_reset();
    base = rx_count;
    wr_en = 1'b1;
    data_in = 8'hF0; tick();
    data_in = 8'h11; tick();
    data_in = 8'h22; tick();
    wr_en = 1'b0;
    for (int i = 3; i < 2 + 4 * BT + BT / 2; i++) tick();
    check("f0_bit3_low_before_reset", {RsTx, empty}, 2'b00);
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", {RsTx, empty, sending, sent, full, overflow}, 6'b110000);
    tick();
    tick();
    rst = 1'b0;
    n_act = 0;
    for (int i = 0; i < 6 * BT; i++) begin
      tick();
      if (!RsTx || sent || sending) n_act++;
    end
    check("idle_after_reset", n_act, 0);
    data_in = 8'h3C;
    wr_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    drain("post_reset");
    check("post_reset_rx_count", rx_count - base, 1);

    // randomized traffic in light, heavy and moderate phases
    do_reset();
    pct[0] = 5;
    pct[1] = 60;
    pct[2] = 15;
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 500; c++) begin
        wr_en   = ($urandom_range(0, 99) < pct[ph]);
        data_in = 8'($urandom_range(0, 255));
        tick();
      end
    end
    wr_en = 1'b0;
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
